// File: rtl/tl_pkg.sv
// tl_pkg: shared encodings and helpers for the N-direction traffic-light
// sequencer.
//   phase_e  : phase encoding driven on tl_phase_ctrl.phase_o
//   mode_e   : operating-mode encoding sampled on tl_phase_ctrl.mode_i
//   sat_step : one saturating +1/-1 step between min_v and max_v
package tl_pkg;

  typedef enum logic [1:0] {
    PH_NIGHT  = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_ALLRED = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_NIGHT = 2'd1,
    MODE_SET   = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_e;

  // Simultaneous up and dn cancel out.
  function automatic logic [31:0] sat_step(input logic [31:0] val,
                                           input logic [31:0] min_v,
                                           input logic [31:0] max_v,
                                           input logic        up,
                                           input logic        dn);
    logic [31:0] res;
    res = val;
    if (up && !dn)
      res = (val >= max_v) ? max_v : val + 32'd1;
    else if (dn && !up)
      res = (val <= min_v) ? min_v : val - 32'd1;
    return res;
  endfunction

endpackage

// File: rtl/tl_cfg_reg.sv
// tl_cfg_reg: CNT_W-bit runtime setting with saturating up/down adjustment.
//   clk_i, rst_ni : clock, async active-low reset (loads DEF)
//   en_i          : this register is currently selected for editing
//   up_i, dn_i    : single-cycle increment / decrement pulses
//   val_o         : current setting
module tl_cfg_reg
  import tl_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int DEF   = 8,
  parameter int MIN   = 1,
  parameter int MAX   = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             dn_i,
  output logic [CNT_W-1:0] val_o
);

  logic [CNT_W-1:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (en_i)
      val_d = CNT_W'(sat_step(32'(val_q), 32'(MIN), 32'(MAX), up_i, dn_i));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) val_q <= CNT_W'(DEF);
    else         val_q <= val_d;
  end

  assign val_o = val_q;

endmodule

// File: rtl/tl_phase_ctrl.sv
// tl_phase_ctrl: rotates right-of-way through N_DIR approaches
// (GREEN -> YELLOW -> ALLRED -> next GREEN), with night flash, hold and
// runtime-editable phase times.
//   clk_i, rst_ni         : clock, async active-low reset
//   tick_i                : 1 s pulse, one clk wide
//   mode_i                : 00 run, 01 night, 10 set, 11 hold
//   sel_i                 : setting select (green[0..N-1], yellow, all-red)
//   key_plus_i, key_sub_i : setting adjust pulses (set mode only)
//   red_o/yellow_o/green_o: lamp drive per approach
//   active_dir_o, phase_o : owner of the current phase and the phase itself
//   remain_o              : ticks left in the phase
//   disp_val_o            : selected setting in set mode, else remain_o
//
// state      | meaning
// PH_NIGHT   | all approaches flash yellow, countdown idle at 0
// PH_GREEN   | active_dir has green, all others red
// PH_YELLOW  | active_dir has yellow, all others red
// PH_ALLRED  | clearance, every approach red
module tl_phase_ctrl
  import tl_pkg::*;
#(
  parameter int N_DIR      = 2,
  parameter int CNT_W      = 8,
  parameter int GREEN_DEF  = 8,
  parameter int YELLOW_DEF = 3,
  parameter int ALLRED_DEF = 1,
  parameter int SEL_W      = $clog2(N_DIR + 2),
  parameter int DIR_W      = $clog2(N_DIR)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic [1:0]       mode_i,
  input  logic [SEL_W-1:0] sel_i,
  input  logic             key_plus_i,
  input  logic             key_sub_i,
  output logic [N_DIR-1:0] red_o,
  output logic [N_DIR-1:0] yellow_o,
  output logic [N_DIR-1:0] green_o,
  output logic [DIR_W-1:0] active_dir_o,
  output logic [1:0]       phase_o,
  output logic [CNT_W-1:0] remain_o,
  output logic [CNT_W-1:0] disp_val_o
);

  localparam int               SET_MAX    = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0] ALLRED_RST = CNT_W'((ALLRED_DEF == 0) ? 1 : ALLRED_DEF);
  localparam logic [DIR_W-1:0] DIR_LAST   = DIR_W'(N_DIR - 1);

  mode_e            mode;
  logic             set_en;
  logic [CNT_W-1:0] green_t [N_DIR];
  logic [CNT_W-1:0] yellow_t, allred_t, allred_ld, sel_val;
  logic [DIR_W-1:0] dir_nxt;

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] remain_q, remain_d, disp_q, disp_d;
  logic [DIR_W-1:0] dir_q, dir_d;
  logic             flash_q, flash_d;
  logic [N_DIR-1:0] red_q, red_d, yellow_q, yellow_d, green_q, green_d;

  assign mode   = mode_e'(mode_i);
  assign set_en = (mode == MODE_SET);

  for (genvar g = 0; g < N_DIR; g++) begin : g_green
    tl_cfg_reg #(.CNT_W(CNT_W), .DEF(GREEN_DEF), .MIN(1), .MAX(SET_MAX)) u_green (
      .clk_i (clk_i), .rst_ni (rst_ni),
      .en_i  (set_en && (sel_i == SEL_W'(g))),
      .up_i  (key_plus_i), .dn_i (key_sub_i),
      .val_o (green_t[g])
    );
  end

  tl_cfg_reg #(.CNT_W(CNT_W), .DEF(YELLOW_DEF), .MIN(1), .MAX(SET_MAX)) u_yellow (
    .clk_i (clk_i), .rst_ni (rst_ni),
    .en_i  (set_en && (sel_i == SEL_W'(N_DIR))),
    .up_i  (key_plus_i), .dn_i (key_sub_i),
    .val_o (yellow_t)
  );

  tl_cfg_reg #(.CNT_W(CNT_W), .DEF(ALLRED_DEF), .MIN(0), .MAX(SET_MAX)) u_allred (
    .clk_i (clk_i), .rst_ni (rst_ni),
    .en_i  (set_en && (sel_i == SEL_W'(N_DIR + 1))),
    .up_i  (key_plus_i), .dn_i (key_sub_i),
    .val_o (allred_t)
  );

  // A zero all-red setting still needs one tick of clearance after night.
  assign allred_ld = (allred_t == '0) ? CNT_W'(1) : allred_t;
  // >= rather than == also pulls an out-of-range direction back to 0.
  assign dir_nxt   = (dir_q >= DIR_LAST) ? '0 : dir_q + DIR_W'(1);

  always_comb begin
    sel_val = '0;
    for (int i = 0; i < N_DIR; i++)
      if (sel_i == SEL_W'(i)) sel_val = green_t[i];
    if (sel_i == SEL_W'(N_DIR))     sel_val = yellow_t;
    if (sel_i == SEL_W'(N_DIR + 1)) sel_val = allred_t;
  end

  always_comb begin
    phase_d  = phase_q;
    remain_d = remain_q;
    dir_d    = dir_q;
    flash_d  = flash_q;
    case (mode)
      MODE_NIGHT: begin
        phase_d  = PH_NIGHT;
        remain_d = '0;
        flash_d  = flash_q ^ tick_i;
      end
      MODE_SET: ;
      default: begin
        if (phase_q == PH_NIGHT) begin
          phase_d  = PH_ALLRED;
          remain_d = allred_ld;
          flash_d  = 1'b0;
        end else if (mode == MODE_RUN && tick_i) begin
          if (remain_q > CNT_W'(1)) begin
            remain_d = remain_q - CNT_W'(1);
          end else begin
            case (phase_q)
              PH_GREEN: begin
                phase_d  = PH_YELLOW;
                remain_d = yellow_t;
              end
              PH_YELLOW: begin
                if (allred_t == '0) begin
                  phase_d  = PH_GREEN;
                  dir_d    = dir_nxt;
                  remain_d = green_t[dir_nxt];
                end else begin
                  phase_d  = PH_ALLRED;
                  remain_d = allred_t;
                end
              end
              default: begin
                phase_d  = PH_GREEN;
                dir_d    = dir_nxt;
                remain_d = green_t[dir_nxt];
              end
            endcase
          end
        end
      end
    endcase

    red_d    = '0;
    yellow_d = '0;
    green_d  = '0;
    for (int i = 0; i < N_DIR; i++) begin
      case (phase_d)
        PH_NIGHT:  yellow_d[i] = flash_d;
        PH_GREEN:  begin
          green_d[i] = (dir_d == DIR_W'(i));
          red_d[i]   = (dir_d != DIR_W'(i));
        end
        PH_YELLOW: begin
          yellow_d[i] = (dir_d == DIR_W'(i));
          red_d[i]    = (dir_d != DIR_W'(i));
        end
        default:   red_d[i] = 1'b1;
      endcase
    end

    disp_d = set_en ? sel_val : remain_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q  <= PH_ALLRED;
      remain_q <= ALLRED_RST;
      dir_q    <= DIR_LAST;
      flash_q  <= 1'b0;
      red_q    <= '1;
      yellow_q <= '0;
      green_q  <= '0;
      disp_q   <= ALLRED_RST;
    end else begin
      phase_q  <= phase_d;
      remain_q <= remain_d;
      dir_q    <= dir_d;
      flash_q  <= flash_d;
      red_q    <= red_d;
      yellow_q <= yellow_d;
      green_q  <= green_d;
      disp_q   <= disp_d;
    end
  end

  assign red_o        = red_q;
  assign yellow_o     = yellow_q;
  assign green_o      = green_q;
  assign active_dir_o = dir_q;
  assign phase_o      = phase_q;
  assign remain_o     = remain_q;
  assign disp_val_o   = disp_q;

endmodule
